// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller:
// forwarding-select encodings, the in-flight slot record and the select priority helper.
package hazard_pkg;

    // Slot destinations are stored at this width; narrower register addresses are zero-extended.
    localparam int unsigned DST_W_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_WB    = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic                 load;
        logic [DST_W_MAX-1:0] dst;
    } slot_t;

    localparam int unsigned SLOT_EX  = 0;
    localparam int unsigned SLOT_MEM = 1;
    localparam int unsigned SLOT_WB  = 2;

    // Youngest producer wins; a load still in EX has no data yet, so it cannot forward from EX/MEM.
    function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic ex_load,
                                          input logic mem_hit, input logic wb_hit);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (ex_hit && !ex_load) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one decode-stage source register against one in-flight slot.
// Register 0 is hard-wired and never produces a match.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned W = DST_W_MAX
) (
    input  logic         slot_valid_i,
    input  logic         slot_wr_i,
    input  logic [W-1:0] slot_dst_i,
    input  logic [W-1:0] src_i,
    input  logic         use_i,
    output logic         match_o
);

    assign match_o = slot_valid_i & slot_wr_i & use_i &
                     (slot_dst_i == src_i) & (src_i != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and operand-forwarding control over the EX/MEM/WB in-flight slots.
// Define HAZARD_MULDIV_EN to add a multiply/divide occupancy stall of MULDIV_LAT cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_dst_i,
    input  logic             id_wr_i,
    input  logic             id_load_i,
    input  logic             id_muldiv_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    slot_t slot_q [3];
    slot_t slot_d [3];

    logic [DST_W_MAX-1:0] rs_ext;
    logic [DST_W_MAX-1:0] rt_ext;
    logic                 match_rs [3];
    logic                 match_rt [3];
    logic                 load_use;

    assign rs_ext = DST_W_MAX'(id_rs_i);
    assign rt_ext = DST_W_MAX'(id_rt_i);

    for (genvar s = 0; s < 3; s++) begin : g_slot
        hazard_match #(.W(DST_W_MAX)) u_match_rs (
            .slot_valid_i (slot_q[s].valid),
            .slot_wr_i    (slot_q[s].wr),
            .slot_dst_i   (slot_q[s].dst),
            .src_i        (rs_ext),
            .use_i        (id_use_rs_i),
            .match_o      (match_rs[s])
        );
        hazard_match #(.W(DST_W_MAX)) u_match_rt (
            .slot_valid_i (slot_q[s].valid),
            .slot_wr_i    (slot_q[s].wr),
            .slot_dst_i   (slot_q[s].dst),
            .src_i        (rt_ext),
            .use_i        (id_use_rt_i),
            .match_o      (match_rt[s])
        );
    end

    assign load_use = id_valid_i & ~flush_i & slot_q[SLOT_EX].load &
                      (match_rs[SLOT_EX] | match_rt[SLOT_EX]);

`ifdef HAZARD_MULDIV_EN
    logic [3:0] busy_q;
    logic [3:0] busy_d;

    assign stall_o = load_use | (busy_q != '0);

    // A flush kills the decode instruction but not a mul/div already occupying the unit.
    always_comb begin
        busy_d = busy_q;
        if (busy_q != '0) begin
            busy_d = busy_q - 4'd1;
        end else if (id_valid_i && id_muldiv_i && !flush_i && !load_use) begin
            busy_d = 4'(MULDIV_LAT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic       unused_muldiv;
    logic [3:0] unused_lat;

    assign unused_muldiv = id_muldiv_i;
    assign unused_lat    = 4'(MULDIV_LAT);
    assign stall_o       = load_use;
`endif

    assign fwd_a_o = fwd_pick(match_rs[SLOT_EX], slot_q[SLOT_EX].load,
                              match_rs[SLOT_MEM], match_rs[SLOT_WB]);
    assign fwd_b_o = fwd_pick(match_rt[SLOT_EX], slot_q[SLOT_EX].load,
                              match_rt[SLOT_MEM], match_rt[SLOT_WB]);

    always_comb begin
        slot_d[SLOT_WB]        = slot_q[SLOT_MEM];
        slot_d[SLOT_MEM]       = slot_q[SLOT_EX];
        slot_d[SLOT_EX].valid  = id_valid_i & ~stall_o & ~flush_i;
        slot_d[SLOT_EX].wr     = id_wr_i;
        slot_d[SLOT_EX].load   = id_load_i;
        slot_d[SLOT_EX].dst    = DST_W_MAX'(id_dst_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule
